micro_sequencer: RTL and testbench
==================================

// Module: micro_sequencer
// PURPOSE
//  Next-address logic for the microcoded control unit. Drives the control address (CAR) into the control ROM.
//  Consumes the ROM's sequencing fields, instruction register IR1.IR0 and ALU flags. One microinstruction per clk.
//  Supersedes the ad-hoc CAR counter + CAR_MUX + testbench-driven mux select; adds conditional branch, opcode map,
//  micro-subroutine stack and halt.
// PARAMETERS
//  CAW          10      control address width (control ROM depth = 2**CAW)
//  MAP_OFFSET   'h04    ROM base of opcode microroutines
//  MAP_SHIFT    2       microroutine slot = 2**MAP_SHIFT words per opcode
//  FETCH_ADDR   'h000   fetch microroutine entry; also reset value of car
//  STACK_DEPTH  4       micro-return stack entries (1..8)
// PORTS
//  clk        in   1          clock; all state updates on rising edge
//  reset      in   1          asynchronous, active-low
//  hlt        in   1          halt request, level sensitive
//  ir         in   16         instruction register {IR1,IR0}; IR1 = opcode
//  flags      in   4          {sign,zero,parity,carry} from status register
//  seq_op     in   3          ROM sequencing op (encoding below)
//  cond_sel   in   2          flag index for BRC: 0 carry, 1 parity, 2 zero, 3 sign
//  cond_pol   in   1          BRC taken when flags[cond_sel]==cond_pol
//  target     in   CAW        ROM branch/call target
//  car        out  CAW        control address to ROM
//  halted     out  1          1 while in HALT state
//  err        out  1          sticky microstack fault
//  depth      out  3          current microstack occupancy
// BEHAVIOUR
//  Reset (async, reset=0): car=FETCH_ADDR, state=RUN, stack empty, depth=0, halted=0, err=0.
//  FSM states RUN, HALT, FAULT. Transitions on the rising edge:
//   RUN->HALT when hlt=1, or when seq_op=HLT; HALT->RUN when hlt=0 and halt not caused by seq_op=HLT.
//   HLT op is left only by reset. RUN->FAULT on stack overflow/underflow; FAULT left only by reset.
//  In HALT/FAULT: car, stack and depth frozen. ROM output is a function of car, so the pending microinstruction
//   re-executes on resume (hlt has priority over any seq_op in the same cycle; op not lost).
//  seq_op in RUN (next car; car+1 wraps mod 2**CAW):
//   0 NEXT   car+1
//   1 JUMP   target
//   2 MAP    ((ir[15:8] << MAP_SHIFT) + MAP_OFFSET) truncated to CAW bits
//   3 BRC    taken ? target : car+1
//   4 CALL   push car+1, car=target
//   5 RET    car=pop
//   6 FETCH  FETCH_ADDR
//   7 HLT    car held, state->HALT (sticky)
//  Stack: LIFO, depth counts 0..STACK_DEPTH. CALL at depth=STACK_DEPTH -> overflow. RET at depth=0 -> underflow.
//   On either fault: err=1, state=FAULT, car held at the faulting address. Stack unchanged.
//  Latency: seq fields/flags sampled at edge N; car valid after edge N (one cycle per microinstruction).
//  flags sampled raw; the caller guarantees they are stable at the sampling edge.
//  Outputs are registered or decoded from registers only. No combinational path from inputs to car.
// CONFIGURATION
//  USTACK_EN defined: CALL/RET and stack operate as above, STACK_DEPTH honoured.
//  USTACK_EN undefined:
//   - no stack storage; CALL behaves as JUMP (no push); RET behaves as FETCH.
//   - depth tied to 0; err tied to 0; FAULT state unreachable.
// TESTING
//  1 reset=0 mid-run with car='h1A3 -> car='h000, depth=0, err=0, halted=0 immediately (async).
//  2 MAP, ir='h0312, MAP_OFFSET=4, MAP_SHIFT=2 -> car='h010 next cycle.
//    MAP with ir[15:8]='hFF -> car=('h3FC+4) mod 1024='h000.
//  3 BRC cond_sel=2, cond_pol=1, target='h080 at car='h020:
//    zero=1 -> car='h080; zero=0 -> car='h021.
//  4 USTACK_EN: CALL 'h100 at car='h030 -> car='h100, depth=1; then RET -> car='h031, depth=0.
//    Five nested CALLs (depth 4) -> err=1, FAULT, car frozen at fifth CALL address.
//    RET at depth 0 -> err=1.
//  5 hlt=1 for 3 cycles while seq_op=JUMP 'h050 at car='h012:
//    car stays 'h012, halted=1; hlt=0 -> next edge car='h050.
//    seq_op=HLT -> halted=1 regardless of hlt until reset.
//  6 USTACK_EN undefined: CALL 'h100 at car='h030 -> car='h100, depth=0;
//    RET -> car='h000; err stays 0.
//    NEXT at car='h3FF -> car='h000 (wrap).

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-address logic for the microcoded control unit.
// Produces the control ROM address (car) from the ROM sequencing fields,
// the opcode in ir[15:8] and the ALU flags. One microinstruction per clk.
//
// Build option: define USTACK_EN to enable the micro-return stack (CALL/RET
// push/pop, overflow/underflow -> FAULT). Without it CALL acts as JUMP,
// RET acts as FETCH, and depth/err read as zero.
//
// A halt is resumed by executing the held microinstruction on the edge where
// hlt drops, so an op that was pending when hlt arrived is not lost.
// depth is 3 bits wide, so with STACK_DEPTH=8 a full stack reads as 0.
//
// state   | meaning
// S_RUN   | executing one microinstruction per clock
// S_HALT  | car/stack frozen; halt_op_q=1 means HLT op, left only by reset
// S_FAULT | microstack overflow/underflow, left only by reset
module micro_sequencer #(
  parameter int CAW         = 10,
  parameter int MAP_OFFSET  = 'h04,
  parameter int MAP_SHIFT   = 2,
  parameter int FETCH_ADDR  = 'h000,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           hlt,
  input  logic [15:0]    ir,
  input  logic [3:0]     flags,
  input  logic [2:0]     seq_op,
  input  logic [1:0]     cond_sel,
  input  logic           cond_pol,
  input  logic [CAW-1:0] target,
  output logic [CAW-1:0] car,
  output logic           halted,
  output logic           err,
  output logic [2:0]     depth
);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_HALT = 2'd1, S_FAULT = 2'd2} state_t;

  localparam logic [2:0] OP_NEXT  = 3'd0;
  localparam logic [2:0] OP_JUMP  = 3'd1;
  localparam logic [2:0] OP_MAP   = 3'd2;
  localparam logic [2:0] OP_BRC   = 3'd3;
  localparam logic [2:0] OP_CALL  = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;
  localparam logic [2:0] OP_FETCH = 3'd6;
  localparam logic [2:0] OP_HLT   = 3'd7;

  localparam logic [CAW-1:0] FETCH_A = CAW'(FETCH_ADDR);

  state_t         state_q, state_d;
  logic           halt_op_q, halt_op_d;
  logic [CAW-1:0] car_q, car_d;
  logic [CAW-1:0] car_inc;
  logic [CAW-1:0] map_addr;
  logic [31:0]    map_full;
  logic           exec;
  logic           taken;
  logic           fault;
  logic           unused_ir;

  assign unused_ir = ^ir[7:0];

  assign car_inc  = car_q + CAW'(1);
  assign map_full = (32'(ir[15:8]) << MAP_SHIFT) + 32'(MAP_OFFSET);
  assign map_addr = map_full[CAW-1:0];
  assign taken    = (flags[cond_sel] == cond_pol);

  // The current microinstruction takes effect in RUN, or on the resume edge of an hlt-caused halt.
  assign exec = !hlt && ((state_q == S_RUN) || ((state_q == S_HALT) && !halt_op_q));

`ifdef USTACK_EN
  localparam int SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [CAW-1:0] stack_q [STACK_DEPTH];
  logic [3:0]     depth_q;
  logic [3:0]     top_idx;
  logic           push, pop;
  logic           full, empty;

  assign top_idx = depth_q - 4'd1;
  assign full    = (depth_q == 4'(STACK_DEPTH));
  assign empty   = (depth_q == 4'd0);
`endif

  // Next control address and stack request for the microinstruction on the ROM output.
  always_comb begin
    car_d = car_q;
    fault = 1'b0;
`ifdef USTACK_EN
    push  = 1'b0;
    pop   = 1'b0;
`endif
    if (exec) begin
      case (seq_op)
        OP_NEXT:  car_d = car_inc;
        OP_JUMP:  car_d = target;
        OP_MAP:   car_d = map_addr;
        OP_BRC:   car_d = taken ? target : car_inc;
`ifdef USTACK_EN
        OP_CALL: begin
          if (full) fault = 1'b1;
          else begin
            push  = 1'b1;
            car_d = target;
          end
        end
        OP_RET: begin
          if (empty) fault = 1'b1;
          else begin
            pop   = 1'b1;
            car_d = stack_q[top_idx[SPW-1:0]];
          end
        end
`else
        OP_CALL:  car_d = target;
        OP_RET:   car_d = FETCH_A;
`endif
        OP_FETCH: car_d = FETCH_A;
        OP_HLT:   car_d = car_q;
        default:  car_d = car_q;
      endcase
    end
  end

  // State register plus the sticky "halted by HLT op" marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      halt_op_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halt_op_q <= halt_op_d;
    end
  end

  // Next-state: hlt wins over any op; HLT op latches; stack faults are terminal.
  always_comb begin
    state_d   = state_q;
    halt_op_d = halt_op_q;
    case (state_q)
      S_RUN, S_HALT: begin
        if (exec) begin
          if (seq_op == OP_HLT) begin
            state_d   = S_HALT;
            halt_op_d = 1'b1;
          end else if (fault) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RUN;
          end
        end else if (state_q == S_RUN) begin
          state_d = S_HALT;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RUN;
    endcase
  end

  // Status outputs decoded from the state register only.
  always_comb begin
    halted = (state_q == S_HALT);
`ifdef USTACK_EN
    err    = (state_q == S_FAULT);
    depth  = depth_q[2:0];
`else
    err    = 1'b0;
    depth  = 3'd0;
`endif
  end

  // Control address register; car_d already holds car when not executing or faulting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) car_q <= FETCH_A;
    else        car_q <= car_d;
  end

  assign car = car_q;

`ifdef USTACK_EN
  // Stack occupancy counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    depth_q <= 4'd0;
    else if (push) depth_q <= depth_q + 4'd1;
    else if (pop)  depth_q <= top_idx;
  end

  // Return-address storage; contents are don't-care above depth, so no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[depth_q[SPW-1:0]] <= car_inc;
  end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed, table-driven bench for micro_sequencer.
// Builds with or without USTACK_EN; the stack sequences follow the build.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       hlt;
  logic [15:0] ir;
  logic [3:0] flags;
  logic [2:0] seq_op;
  logic [1:0] cond_sel;
  logic       cond_pol;
  logic [9:0] target;
  logic [9:0] car;
  logic       halted;
  logic       err;
  logic [2:0] depth;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .clk(clk), .reset(reset), .hlt(hlt), .ir(ir), .flags(flags),
    .seq_op(seq_op), .cond_sel(cond_sel), .cond_pol(cond_pol), .target(target),
    .car(car), .halted(halted), .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hlt;
    logic [15:0] ir;
    logic [3:0]  flags;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic        pol;
    logic [9:0]  tgt;
    logic [9:0]  car;
    logic        halted;
    logic        err;
    logic [2:0]  depth;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [9:0] ecar, input logic eh,
                       input logic ee, input logic [2:0] ed);
    checks++;
    if (car !== ecar || halted !== eh || err !== ee || depth !== ed) begin
      errors++;
      $display("FAIL %s: car=%h halted=%b err=%b depth=%0d, expected car=%h halted=%b err=%b depth=%0d",
               name, car, halted, err, depth, ecar, eh, ee, ed);
    end
  endtask

  task automatic step(input logic h, input logic [15:0] i, input logic [3:0] f,
                      input logic [2:0] op, input logic [1:0] s, input logic p,
                      input logic [9:0] t);
    hlt = h; ir = i; flags = f; seq_op = op; cond_sel = s; cond_pol = p; target = t;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic async_reset(input string name);
    #3 reset = 1'b0;
    #1 check(name, 10'h000, 1'b0, 1'b0, 3'd0);
    #1 reset = 1'b1;
  endtask

  initial begin
    // hlt ir flags op sel pol tgt | car halted err depth
    vecs[0]  = '{1'b0, 16'h0000, 4'b0000, 3'd0, 2'd0, 1'b0, 10'h000, 10'h001, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h020, 10'h020, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 16'h0000, 4'b0100, 3'd3, 2'd2, 1'b1, 10'h080, 10'h080, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h020, 10'h020, 1'b0, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 16'h0000, 4'b0000, 3'd3, 2'd2, 1'b1, 10'h080, 10'h021, 1'b0, 1'b0, 3'd0};
    vecs[5]  = '{1'b0, 16'h0000, 4'b1110, 3'd3, 2'd0, 1'b0, 10'h100, 10'h100, 1'b0, 1'b0, 3'd0};
    vecs[6]  = '{1'b0, 16'h0312, 4'b0000, 3'd2, 2'd0, 1'b0, 10'h000, 10'h010, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{1'b0, 16'hFF00, 4'b0000, 3'd2, 2'd0, 1'b0, 10'h155, 10'h000, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 16'h0000, 4'b0000, 3'd0, 2'd0, 1'b0, 10'h000, 10'h000, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h012, 10'h012, 1'b0, 1'b0, 3'd0};
    vecs[11] = '{1'b1, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h050, 10'h012, 1'b1, 1'b0, 3'd0};
    vecs[12] = '{1'b1, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h050, 10'h012, 1'b1, 1'b0, 3'd0};
    vecs[13] = '{1'b1, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h050, 10'h012, 1'b1, 1'b0, 3'd0};
    vecs[14] = '{1'b0, 16'h0000, 4'b0000, 3'd1, 2'd0, 1'b0, 10'h050, 10'h050, 1'b0, 1'b0, 3'd0};
    vecs[15] = '{1'b0, 16'h0000, 4'b1000, 3'd3, 2'd3, 1'b1, 10'h0AA, 10'h0AA, 1'b0, 1'b0, 3'd0};
    vecs[16] = '{1'b0, 16'h0000, 4'b0000, 3'd3, 2'd1, 1'b1, 10'h200, 10'h0AB, 1'b0, 1'b0, 3'd0};
    vecs[17] = '{1'b0, 16'h0000, 4'b0000, 3'd6, 2'd0, 1'b0, 10'h3C0, 10'h000, 1'b0, 1'b0, 3'd0};
    vecs[18] = '{1'b0, 16'h0000, 4'b0111, 3'd3, 2'd2, 1'b0, 10'h040, 10'h001, 1'b0, 1'b0, 3'd0};

    reset = 1'b0; hlt = 1'b0; ir = '0; flags = '0; seq_op = 3'd0;
    cond_sel = '0; cond_pol = 1'b0; target = '0;
    @(posedge clk); #1;
    check("reset_state", 10'h000, 1'b0, 1'b0, 3'd0);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    // The first NEXT after reset release advanced car at that edge.
    check("first_next", 10'h001, 1'b0, 1'b0, 3'd0);
    step(1'b0, '0, '0, 3'd6, '0, 1'b0, '0);
    check("fetch_to_zero", 10'h000, 1'b0, 1'b0, 3'd0);

    for (int k = 0; k < NV; k++) begin
      step(vecs[k].hlt, vecs[k].ir, vecs[k].flags, vecs[k].op, vecs[k].sel,
           vecs[k].pol, vecs[k].tgt);
      check($sformatf("vec%0d", k), vecs[k].car, vecs[k].halted, vecs[k].err, vecs[k].depth);
    end

`ifdef USTACK_EN
    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h030);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h100);
    check("call_push", 10'h100, 1'b0, 1'b0, 3'd1);
    step(1'b0, '0, '0, 3'd5, '0, 1'b0, 10'h3AA);
    check("ret_pop", 10'h031, 1'b0, 1'b0, 3'd0);
    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h200);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h210);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h220);
    check("nest_d2", 10'h220, 1'b0, 1'b0, 3'd2);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h230);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h240);
    check("nest_d4", 10'h240, 1'b0, 1'b0, 3'd4);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h250);
    check("overflow", 10'h240, 1'b0, 1'b1, 3'd4);
    step(1'b0, '0, '0, 3'd0, '0, 1'b0, 10'h000);
    check("fault_frozen", 10'h240, 1'b0, 1'b1, 3'd4);
    async_reset("reset_from_fault");
    step(1'b0, '0, '0, 3'd5, '0, 1'b0, 10'h123);
    check("underflow", 10'h000, 1'b0, 1'b1, 3'd0);
    async_reset("reset_after_underflow");
    // Nested returns unwind in LIFO order.
    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h060);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h070);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h090);
    step(1'b0, '0, '0, 3'd5, '0, 1'b0, 10'h000);
    check("ret_inner", 10'h071, 1'b0, 1'b0, 3'd1);
    step(1'b0, '0, '0, 3'd5, '0, 1'b0, 10'h000);
    check("ret_outer", 10'h061, 1'b0, 1'b0, 3'd0);
`else
    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h030);
    step(1'b0, '0, '0, 3'd4, '0, 1'b0, 10'h100);
    check("call_as_jump", 10'h100, 1'b0, 1'b0, 3'd0);
    step(1'b0, '0, '0, 3'd5, '0, 1'b0, 10'h3AA);
    check("ret_as_fetch", 10'h000, 1'b0, 1'b0, 3'd0);
    step(1'b0, '0, '0, 3'd5, '0, 1'b0, 10'h3AA);
    check("ret_empty_no_err", 10'h000, 1'b0, 1'b0, 3'd0);
`endif

    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h1A3);
    check("jump_1a3", 10'h1A3, 1'b0, 1'b0, 3'd0);
    async_reset("async_reset_mid_run");

    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h005);
    step(1'b0, '0, '0, 3'd7, '0, 1'b0, 10'h0FF);
    check("hlt_op", 10'h005, 1'b1, 1'b0, 3'd0);
    step(1'b1, '0, '0, 3'd1, '0, 1'b0, 10'h0FF);
    check("hlt_op_hlt_high", 10'h005, 1'b1, 1'b0, 3'd0);
    step(1'b0, '0, '0, 3'd1, '0, 1'b0, 10'h0FF);
    check("hlt_op_sticky", 10'h005, 1'b1, 1'b0, 3'd0);
    step(1'b0, '0, '0, 3'd0, '0, 1'b0, 10'h0FF);
    check("hlt_op_sticky2", 10'h005, 1'b1, 1'b0, 3'd0);
    async_reset("reset_from_hlt_op");
    step(1'b0, '0, '0, 3'd0, '0, 1'b0, 10'h000);
    check("run_after_reset", 10'h001, 1'b0, 1'b0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
